// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared types, constants and helper functions for the DES
//                key schedule block: FSM state encoding, the PC-1 selection
//                table, the per-round left-shift schedule, a byte-wise odd
//                parity check and a 28-bit rotate-left helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_GEN   = 2'd2,
        S_READY = 2'd3
    } state_t;

    // PC-1 in DES bit numbering (1 = MSB of the 64-bit key). Entry j gives
    // the source of output bit j+1, output bit 1 being bit 55 of {C,D}.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Left-rotate amount applied to C and D in each generation round.
    localparam int SHIFT_SCHED [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Every byte of the key must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [63:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (!(^key[8*b +: 8])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Only rotations of 1 and 2 occur in the schedule; anything else passes
    // the value through unchanged.
    function automatic logic [27:0] rot28(input logic [27:0] x, input int amount);
        logic [27:0] res;
        case (amount)
            1:       res = {x[26:0], x[27]};
            2:       res = {x[25:0], x[27:26]};
            default: res = x;
        endcase
        return res;
    endfunction

    // Map the 64-bit key onto the 56-bit {C0,D0}; DES bit n lives at key[64-n].
    function automatic logic [55:0] pc1_perm(input logic [63:0] key);
        logic [55:0] res;
        res = '0;
        for (int j = 0; j < 56; j++) begin
            res[55-j] = key[64-PC1[j]];
        end
        return res;
    endfunction

endpackage : des_pkg
`default_nettype wire

// File: rtl/des_key_table.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_table
//  Description : DEPTH x WIDTH register file holding the rotated C/D halves.
//                One synchronous write port, one registered read port. The
//                read register gives the one-cycle request latency and keeps
//                its value between reads.
//  Ports       : clk_in, rst_n_in      clock / async active-low reset
//                i_wr_en/idx/data      write port
//                i_rd_en/idx           read request
//                o_rd_data             registered read data (resets to 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module des_key_table #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 56,
    parameter int IDX_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [WIDTH-1:0] o_rd_data
);

    // Storage is not reset: validity is tracked by the controller.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk_in) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : des_key_table
`default_nettype wire

// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_sched
//  Description : DES sub-key responder. Accepts a 64-bit key, checks byte
//                parity, applies PC-1, then pre-computes the 16 rotated
//                {C_i,D_i} values into a table and serves indexed requests
//                with one cycle of latency.
//  Ports       : clk_in, rst_n_in             clock / async active-low reset
//                key_in_valid, key_in         key load (accepted if key_ready)
//                key_ready                    block can take a new key
//                check_valid, check_error_out parity result pulse / sticky flag
//                table_valid                  all table entries generated
//                req_valid_in, req_idx_in     sub-key request
//                req_ready                    request accepted (== table_valid)
//                sub_key_out, sub_key_idx_out served {C,D} and its index
//                sub_key_out_valid            one-cycle response pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module des_key_sched
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        key_in_valid,
    input  logic [63:0] key_in,
    output logic        key_ready,
    output logic        check_valid,
    output logic        check_error_out,
    output logic        table_valid,
    input  logic        req_valid_in,
    input  logic [3:0]  req_idx_in,
    output logic        req_ready,
    output logic [55:0] sub_key_out,
    output logic [3:0]  sub_key_idx_out,
    output logic        sub_key_out_valid
);

    localparam int              IDX_W        = 4;
    localparam logic [IDX_W-1:0] c_last_round = IDX_W'(NUM_ROUNDS - 1);

    state_t             r_state;
    logic [63:0]        r_key;
    logic [55:0]        r_cd;
    logic [IDX_W-1:0]   r_round;
    logic               r_key_ready;
    logic               r_check_valid;
    logic               r_check_error;
    logic               r_table_valid;
    logic               r_sk_valid;
    logic [IDX_W-1:0]   r_sk_idx;

    logic               w_key_accept;
    logic               w_req_accept;
    logic               w_wr_en;
    logic [55:0]        w_cd_next;
    logic [55:0]        w_rd_data;

    assign w_key_accept = key_in_valid & r_key_ready;
    // The request is judged against the table state before this edge, so a
    // request arriving together with a new key still reads the old table.
    assign w_req_accept = req_valid_in & r_table_valid;
    assign w_wr_en      = (r_state == S_GEN);

    always_comb begin
        w_cd_next = {rot28(r_cd[55:28], SHIFT_SCHED[r_round]),
                     rot28(r_cd[27:0],  SHIFT_SCHED[r_round])};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= S_IDLE;
            r_key         <= '0;
            r_cd          <= '0;
            r_round       <= '0;
            r_key_ready   <= 1'b1;
            r_check_valid <= 1'b0;
            r_check_error <= 1'b0;
            r_table_valid <= 1'b0;
            r_sk_valid    <= 1'b0;
            r_sk_idx      <= '0;
        end else begin
            r_check_valid <= 1'b0;
            r_sk_valid    <= w_req_accept;
            if (w_req_accept) begin
                r_sk_idx <= req_idx_in;
            end

            case (r_state)
                S_IDLE, S_READY: begin
                    if (w_key_accept) begin
                        r_key         <= key_in;
                        r_key_ready   <= 1'b0;
                        r_check_error <= 1'b0;
                        r_table_valid <= 1'b0;
                        r_state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_check_valid <= 1'b1;
                    if (!odd_parity_ok(r_key)) begin
                        r_check_error <= 1'b1;
                        r_key_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cd    <= pc1_perm(r_key);
                        r_round <= '0;
                        r_state <= S_GEN;
                    end
                end
                S_GEN: begin
                    r_cd <= w_cd_next;
                    if (r_round == c_last_round) begin
                        r_round       <= '0;
                        r_table_valid <= 1'b1;
                        r_key_ready   <= 1'b1;
                        r_state       <= S_READY;
                    end else begin
                        r_round <= r_round + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    des_key_table #(
        .DEPTH (NUM_ROUNDS),
        .WIDTH (56),
        .IDX_W (IDX_W)
    ) u_table (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_round),
        .i_wr_data (w_cd_next),
        .i_rd_en   (w_req_accept),
        .i_rd_idx  (req_idx_in),
        .o_rd_data (w_rd_data)
    );

    assign key_ready         = r_key_ready;
    assign check_valid       = r_check_valid;
    assign check_error_out   = r_check_error;
    assign table_valid       = r_table_valid;
    assign req_ready         = r_table_valid;
    assign sub_key_out       = w_rd_data;
    assign sub_key_idx_out   = r_sk_idx;
    assign sub_key_out_valid = r_sk_valid;

endmodule : des_key_sched
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_key_sched
//  Description : Self-checking bench for des_key_sched. Expected sub-keys
//                are produced from the DES key-schedule definition (PC-1
//                table plus cumulative rotation) and queued on issue; a
//                monitor pops and compares on every response pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_sched;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        key_in_valid;
    logic [63:0] key_in;
    logic        key_ready;
    logic        check_valid;
    logic        check_error_out;
    logic        table_valid;
    logic        req_valid_in;
    logic [3:0]  req_idx_in;
    logic        req_ready;
    logic [55:0] sub_key_out;
    logic [3:0]  sub_key_idx_out;
    logic        sub_key_out_valid;

    always #5 clk_in = ~clk_in;

    des_key_sched #(.NUM_ROUNDS(16)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .key_in_valid      (key_in_valid),
        .key_in            (key_in),
        .key_ready         (key_ready),
        .check_valid       (check_valid),
        .check_error_out   (check_error_out),
        .table_valid       (table_valid),
        .req_valid_in      (req_valid_in),
        .req_idx_in        (req_idx_in),
        .req_ready         (req_ready),
        .sub_key_out       (sub_key_out),
        .sub_key_idx_out   (sub_key_idx_out),
        .sub_key_out_valid (sub_key_out_valid)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [55:0] key;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb_q [$];
    bit          chk_q [$];
    logic [55:0] m_tab [16];
    bit          m_valid = 1'b0;

    localparam int REF_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_parity_ok(input logic [63:0] k);
        bit ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (($countones(k[8*b +: 8]) % 2) == 0) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [55:0] ref_pc1(input logic [63:0] k);
        logic [55:0] r = '0;
        for (int j = 1; j <= 56; j++) begin
            r[56-j] = k[64-REF_PC1[j-1]];
        end
        return r;
    endfunction

    function automatic logic [27:0] ref_rotl(input logic [27:0] x, input int s);
        logic [55:0] t;
        t = {28'b0, x};
        t = (t << s) | (t >> (28 - s));
        return t[27:0];
    endfunction

    // Entry i is {C0,D0} rotated by the total shift of rounds 1..i+1.
    function automatic logic [55:0] ref_row(input logic [63:0] k, input int i);
        logic [55:0] cd = ref_pc1(k);
        int s = 0;
        for (int r = 0; r <= i; r++) begin
            s += (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
        end
        s = s % 28;
        return {ref_rotl(cd[55:28], s), ref_rotl(cd[27:0], s)};
    endfunction

    function automatic logic [63:0] fix_parity(input logic [63:0] k);
        logic [63:0] r = k;
        for (int b = 0; b < 8; b++) begin
            r[8*b] = ~(^r[8*b+1 +: 7]);
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        exp_t e;
        bit   ce;
        if (sub_key_out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_subkey: got idx %0d data %h, none expected",
                         sub_key_idx_out, sub_key_out);
            end else begin
                e = sb_q.pop_front();
                check("subkey_idx", 64'(sub_key_idx_out), 64'(e.idx));
                check("subkey_data", 64'(sub_key_out), 64'(e.key));
            end
        end
        if (check_valid === 1'b1) begin
            if (chk_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_check_valid: got pulse, none expected");
            end else begin
                ce = chk_q.pop_front();
                check("check_error", 64'(check_error_out), 64'(ce));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic request(input int idx);
        req_valid_in = 1'b1;
        req_idx_in   = 4'(idx);
        if (m_valid) sb_q.push_back('{4'(idx), m_tab[idx]});
        cyc();
        req_valid_in = 1'b0;
    endtask

    // Single request with a fixed expected value; also checks latency and hold.
    task automatic request_exp(input int idx, input logic [55:0] exp);
        req_valid_in = 1'b1;
        req_idx_in   = 4'(idx);
        sb_q.push_back('{4'(idx), exp});
        cyc();
        req_valid_in = 1'b0;
        @(negedge clk_in);
        check("req_latency_pulse", 64'(sub_key_out_valid), 64'd1);
        @(negedge clk_in);
        @(negedge clk_in);
        check("pulse_one_cycle", 64'(sub_key_out_valid), 64'd0);
        check("subkey_hold", 64'(sub_key_out), 64'(exp));
    endtask

    task automatic load_key(input logic [63:0] k, input int same_req, input bit gen_req);
        bit ok = ref_parity_ok(k);
        check("key_ready_before_load", 64'(key_ready), 64'd1);
        key_in_valid = 1'b1;
        key_in       = k;
        if (same_req >= 0) begin
            req_valid_in = 1'b1;
            req_idx_in   = 4'(same_req);
            if (m_valid) sb_q.push_back('{4'(same_req), m_tab[same_req]});
        end
        chk_q.push_back(!ok);
        cyc();
        key_in_valid = 1'b0;
        req_valid_in = 1'b0;
        m_valid      = 1'b0;
        if (ok) begin
            for (int i = 0; i < 16; i++) m_tab[i] = ref_row(k, i);
        end
        check("key_ready_after_accept", 64'(key_ready), 64'd0);
        check("table_valid_after_accept", 64'(table_valid), 64'd0);
        for (int n = 1; n <= 17; n++) begin
            if (gen_req && n == 6) begin
                req_valid_in = 1'b1;
                req_idx_in   = 4'($urandom_range(0, 15));
            end
            cyc();
            req_valid_in = 1'b0;
            if (n == 1 && !ok) check("key_ready_after_error", 64'(key_ready), 64'd1);
            if (n == 16) check("table_valid_at_16", 64'(table_valid), 64'd0);
            if (n == 16 && ok) check("key_ready_in_gen", 64'(key_ready), 64'd0);
            if (n == 17) begin
                check("table_valid_at_17", 64'(table_valid), 64'(ok));
                check("req_ready_at_17", 64'(req_ready), 64'(ok));
                check("key_ready_at_17", 64'(key_ready), 64'd1);
            end
        end
        m_valid = ok;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_key_ready"}, 64'(key_ready), 64'd1);
        check({tag, "_check_valid"}, 64'(check_valid), 64'd0);
        check({tag, "_check_error"}, 64'(check_error_out), 64'd0);
        check({tag, "_table_valid"}, 64'(table_valid), 64'd0);
        check({tag, "_sub_key_out"}, 64'(sub_key_out), 64'd0);
        check({tag, "_sub_key_idx"}, 64'(sub_key_idx_out), 64'd0);
        check({tag, "_sub_key_valid"}, 64'(sub_key_out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] k;
        rst_n_in     = 1'b0;
        key_in_valid = 1'b0;
        key_in       = '0;
        req_valid_in = 1'b0;
        req_idx_in   = '0;
        repeat (3) cyc();
        check_reset_values("reset");
        rst_n_in = 1'b1;
        cyc();

        // Reference key with a request during generation (must be ignored).
        load_key(64'h133457799BBCDFF1, -1, 1'b1);
        request_exp(0, 56'hE19955FAACCF1E);
        request_exp(15, 56'hF0CCAAF556678F);

        // Back-to-back descending requests.
        for (int i = 15; i >= 0; i--) request(i);

        // New key with a same-cycle request served from the old table.
        load_key(64'h0E329232EA6D0D73, 3, 1'b0);
        repeat (20) request($urandom_range(0, 15));

        // Parity failure: no table, requests ignored.
        load_key(64'h0, -1, 1'b0);
        request(5);
        repeat (3) cyc();
        check("table_valid_after_error", 64'(table_valid), 64'd0);

        // Randomised keys, mostly with good parity.
        for (int t = 0; t < 5; t++) begin
            k = {$urandom, $urandom};
            if (t != 2) k = fix_parity(k);
            load_key(k, -1, 1'b0);
            repeat (8) request($urandom_range(0, 15));
        end

        // Reset while generating round 7.
        k = fix_parity({$urandom, $urandom});
        key_in_valid = 1'b1;
        key_in       = k;
        chk_q.push_back(1'b0);
        cyc();
        key_in_valid = 1'b0;
        m_valid      = 1'b0;
        repeat (8) cyc();
        rst_n_in = 1'b0;
        #1;
        check_reset_values("midgen_reset");
        cyc();
        rst_n_in = 1'b1;
        cyc();
        load_key(64'h0E329232EA6D0D73, -1, 1'b0);
        for (int i = 0; i < 16; i++) request(i);

        repeat (3) cyc();
        check("subkey_queue_empty", 64'(sb_q.size()), 64'd0);
        check("check_queue_empty", 64'(chk_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_des_key_sched
`default_nettype wire
